pipeline_register_chain: RTL

PIPELINE_REGISTER_CHAIN -- requirements
Module: pipeline_register_chain

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/pipe_stage.sv | 38 +++
 rtl/pipeline_register_chain.sv | 73 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-register definitions: bundle widths and control-field layout
// reused by the IF/ID, ID/EX, EX/MEM and MEM/WB register instances.
package pipeline_pkg;

    localparam int CTRL_W    = 10;
    localparam int DATA_W    = 175;
    localparam int MAX_DEPTH = 4;

    // Control bundle bit offsets (LSB first)
    localparam int ALU_SRC_OFS     = 0;
    localparam int ALU_CONTROL_OFS = 1;
    localparam int BRANCH_OFS      = 4;
    localparam int JUMP_OFS        = 5;
    localparam int MEM_WRITE_OFS   = 6;
    localparam int RESULT_SRC_OFS  = 7;
    localparam int REG_WRITE_OFS   = 9;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: valid/ctrl/data with stall hold and flush bubble.
module pipe_stage #(
    parameter int CTRL_W     = 10,
    parameter int DATA_W     = 175,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              src_valid,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    import pipeline_pkg::*;

    // Flush wins over stall; ctrl is gated by valid so bubbles never write.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA)
                data <= '0;
        end else if (!stall) begin
            valid <= src_valid;
            ctrl  <= src_valid ? src_ctrl : '0;
            data  <= src_data;
        end
    end

endmodule

// File: rtl/pipeline_register_chain.sv
// DEPTH-stage pipeline register with per-stage flush, global stall and a
// saturating count of flush events.
module pipeline_register_chain #(
    parameter int CTRL_W     = pipeline_pkg::CTRL_W,
    parameter int DATA_W     = pipeline_pkg::DATA_W,
    parameter int DEPTH      = 1,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush,
    input  logic              cnt_clr,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  bubble_count
);
    import pipeline_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index 0 is the chain input; index k+1 is the output of stage k.
    logic [DEPTH:0]             vld_pipe;
    logic [DEPTH:0][CTRL_W-1:0] ctrl_pipe;
    logic [DEPTH:0][DATA_W-1:0] data_pipe;

    assign vld_pipe[0]  = valid_in;
    assign ctrl_pipe[0] = ctrl_in;
    assign data_pipe[0] = data_in;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .stall     (stall),
            .flush     (flush[k]),
            .src_valid (vld_pipe[k]),
            .src_ctrl  (ctrl_pipe[k]),
            .src_data  (data_pipe[k]),
            .valid     (vld_pipe[k+1]),
            .ctrl      (ctrl_pipe[k+1]),
            .data      (data_pipe[k+1])
        );
    end

    assign valid_out = vld_pipe[DEPTH];
    assign ctrl_out  = ctrl_pipe[DEPTH];
    assign data_out  = data_pipe[DEPTH];

    logic any_flush;
    assign any_flush = |flush;

    // Clear takes priority but a same-cycle flush still counts once.
    always_ff @(posedge clk) begin
        if (reset)
            bubble_count <= '0;
        else if (cnt_clr)
            bubble_count <= any_flush ? CNT_ONE : '0;
        else if (any_flush && bubble_count != CNT_MAX)
            bubble_count <= bubble_count + CNT_ONE;
    end

endmodule
